// File: rtl/seq_alu.sv
// Handshaked integer ALU: single-cycle logic/adder/shift ops plus
// multi-cycle shift-add multiply and restoring divide.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Results,
    output logic             zero,
    output logic             Overflow,
    output logic             Carry
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nx;
    logic                 accept, is_multi, last;
    logic [1:0]           op;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   acc, acc_nx;
    logic [SHW-1:0]       cnt;
    logic [WIDTH:0]       add_s, sub_s;
    logic                 add_v, sub_v;
    logic [WIDTH-1:0]     s_res, m_res;
    logic                 s_c, s_v;
    logic [SHW-1:0]       sh;
    logic [WIDTH:0]       psum, rem_sh, rem_try;

    assign add_s = {1'b0, A} + {1'b0, B};
    assign sub_s = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    assign add_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
    assign sub_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
    assign sh    = B[SHW-1:0];

    always_comb begin
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        case (Mode)
            4'b0000: begin
                s_res = add_s[WIDTH-1:0];
                s_c   = add_s[WIDTH];
                s_v   = add_v;
            end
            4'b0001: begin
                s_res = sub_s[WIDTH-1:0];
                s_c   = sub_s[WIDTH];
                s_v   = sub_v;
            end
            4'b0010: s_res = ~A;
            4'b0011: s_res = A & B;
            4'b0100: s_res = A | B;
            4'b0101: s_res = A ^ B;
            4'b0110: begin
                s_res = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_v};
                s_c   = sub_s[WIDTH];
                s_v   = sub_v;
            end
            4'b0111: begin
                s_res = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1:0] == '0};
                s_c   = sub_s[WIDTH];
                s_v   = sub_v;
            end
            4'b1000: begin
                s_res = {{(WIDTH-1){1'b0}}, ~sub_s[WIDTH]};
                s_c   = sub_s[WIDTH];
                s_v   = sub_v;
            end
            4'b1001: s_res = A << sh;
            4'b1010: s_res = A >> sh;
            4'b1011: s_res = $unsigned($signed(A) >>> sh);
            default: s_res = '0;
        endcase
    end

    // acc holds {partial/remainder, multiplier/dividend->quotient}
    assign psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_try = rem_sh - {1'b0, opb};

    always_comb begin
        acc_nx = acc;
        if (!op[1])
            acc_nx = {psum, acc[WIDTH-1:1]};
        else if (!rem_try[WIDTH])
            acc_nx = {rem_try[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    assign m_res     = op[0] ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
    assign is_multi  = (Mode[3:2] == 2'b11);
    assign last      = (state == BUSY) && (cnt == SHW'(WIDTH-1));
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (accept) state_nx = is_multi ? BUSY : DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Results  <= '0;
            zero     <= 1'b0;
            Overflow <= 1'b0;
            Carry    <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            opb      <= '0;
            op       <= '0;
        end else if (accept) begin
            op  <= Mode[1:0];
            opb <= B;
            cnt <= '0;
            if (is_multi) begin
                acc <= {{WIDTH{1'b0}}, A};
            end else begin
                Results  <= s_res;
                zero     <= (s_res == '0);
                Carry    <= s_c;
                Overflow <= s_v;
            end
        end else if (state == BUSY) begin
            acc <= acc_nx;
            cnt <= cnt + SHW'(1);
            if (last) begin
                Results  <= m_res;
                zero     <= (m_res == '0);
                Carry    <= 1'b0;
                Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases, back-to-back,
// reset abort and randomized ops against an arithmetic reference model.
module tb_seq_alu;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [3:0]   Mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Results;
    logic         zero, Overflow, Carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Mode(Mode), .out_valid(out_valid),
        .out_ready(out_ready), .Results(Results), .zero(zero),
        .Overflow(Overflow), .Carry(Carry)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (W-1))) ? v - (1 << W) : v;
    endfunction

    task automatic model(input int m, input int a, input int b,
                         output int r, output int c, output int v);
        int s, sa, sb, sh;
        sa = sx(a); sb = sx(b); sh = b % W;
        r = 0; c = 0; v = 0;
        case (m)
            0: begin
                s = a + b; r = s & MASK; c = int'(s > MASK);
                v = int'((sa + sb) > MASK/2 || (sa + sb) < -(MASK/2) - 1);
            end
            1, 6, 7, 8: begin
                s = a + (MASK - b) + 1; c = int'(s > MASK);
                v = int'((sa - sb) > MASK/2 || (sa - sb) < -(MASK/2) - 1);
                if (m == 1) r = s & MASK;
                if (m == 6) r = int'(sa < sb);
                if (m == 7) r = int'(a == b);
                if (m == 8) r = int'(a < b);
            end
            2:  r = MASK - a;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            9:  r = (a << sh) & MASK;
            10: r = a >> sh;
            11: r = (sa >>> sh) & MASK;
            12: r = (a * b) & MASK;
            13: r = (a * b) >> W;
            14: r = (b == 0) ? MASK : a / b;
            default: r = (b == 0) ? a : a % b;
        endcase
    endtask

    // issue one op, check latency/result/flags, hold back-pressure, drain
    task automatic run_op(input int m, input int a, input int b,
                          input int hold, output int res, output int flg);
        int n, lat, er, ec, ev;
        logic [W-1:0] r0;
        A = W'(a); B = W'(b); Mode = 4'(m);
        in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("accept_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); Mode = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check($sformatf("lat_m%0d", m), 32'(lat), (m >= 12) ? 32'(W) : 32'd0);
        model(m, a, b, er, ec, ev);
        check($sformatf("res_m%0d_%0h_%0h", m, a, b), 32'(Results), 32'(er));
        check("zero", 32'(zero), 32'(er == 0));
        check("carry", 32'(Carry), 32'(ec));
        check("ovf", 32'(Overflow), 32'(ev));
        res = int'(Results);
        flg = {29'd0, zero, Carry, Overflow};
        r0 = Results;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_res", 32'(Results), 32'(r0));
            check("hold_flags", 32'({zero, Carry, Overflow}), 32'(flg));
            check("hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain", 32'(out_valid), 32'd0);
    endtask

    int res, flg, lat;
    int bm[3], ba[3], bb[3];
    int er, ec, ev;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_res", 32'(Results), 32'd0);
        check("rst_flags", 32'({zero, Carry, Overflow}), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_rdy", 32'(in_ready), 32'd1);

        run_op(0, 8'h7F, 8'h01, 0, res, flg);
        check("tp_add", 32'(res), 32'h80);
        check("tp_add_f", 32'(flg), 32'b001);
        run_op(1, 8'h05, 8'h05, 0, res, flg);
        check("tp_sub", 32'(res), 32'h00);
        check("tp_sub_f", 32'(flg), 32'b110);
        run_op(7, 8'h05, 8'h05, 0, res, flg);
        check("tp_eq", 32'(res), 32'h01);
        run_op(6, 8'h80, 8'h01, 0, res, flg);
        check("tp_slt", 32'(res), 32'h01);
        run_op(8, 8'h80, 8'h01, 0, res, flg);
        check("tp_sltu", 32'(res), 32'h00);
        run_op(11, 8'h80, 8'h03, 0, res, flg);
        check("tp_sra", 32'(res), 32'hF0);
        run_op(10, 8'h80, 8'h03, 0, res, flg);
        check("tp_srl", 32'(res), 32'h10);
        run_op(12, 8'hFF, 8'hFF, 3, res, flg);
        check("tp_mull", 32'(res), 32'h01);
        run_op(13, 8'hFF, 8'hFF, 3, res, flg);
        check("tp_mulh", 32'(res), 32'hFE);
        run_op(14, 200, 7, 0, res, flg);
        check("tp_divu", 32'(res), 32'h1C);
        run_op(15, 200, 7, 0, res, flg);
        check("tp_remu", 32'(res), 32'h04);
        run_op(14, 8'h2A, 0, 0, res, flg);
        check("tp_div0", 32'(res), 32'hFF);
        run_op(15, 8'h2A, 0, 0, res, flg);
        check("tp_rem0", 32'(res), 32'h2A);

        bm = '{0, 5, 9}; ba = '{8'h13, 8'hA5, 8'h0B}; bb = '{8'h22, 8'h3C, 8'h05};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = W'(ba[i]); B = W'(bb[i]); Mode = 4'(bm[i]);
            @(posedge clk); #1;
            model(bm[i], ba[i], bb[i], er, ec, ev);
            check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("b2b_res%0d", i), 32'(Results), 32'(er));
            check($sformatf("b2b_rdy%0d", i), 32'(in_ready), 32'd1);
        end
        A = 8'h0D; B = 8'h0B; Mode = 4'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_busy", 32'(out_valid), 32'd0);
        check("b2b_busy_rdy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("b2b_mul_lat", 32'(lat), 32'(W));
        check("b2b_mul", 32'(Results), 32'd143);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_drain", 32'(out_valid), 32'd0);

        A = 8'hC8; B = 8'h07; Mode = 4'd14; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_busy_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_busy_valid", 32'(out_valid), 32'd0);
        check("rst_busy_res", 32'(Results), 32'd0);
        check("rst_busy_flags", 32'({zero, Carry, Overflow}), 32'd0);
        check("rst_busy_rdy2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rel_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'(out_valid), 32'd0);
        end
        run_op(0, 8'h21, 8'h12, 0, res, flg);
        check("post_rst_add", 32'(res), 32'h33);

        for (int i = 0; i < 150; i++) begin
            int m, a, b;
            m = int'($urandom_range(0, 15));
            a = int'($urandom_range(0, MASK));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MASK));
            run_op(m, a, b, int'($urandom_range(0, 2)), res, flg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

endmodule
